// File: rtl/wb_stage.sv
// wb_stage: write-back arbiter (loads over buffered/bypassed ALU results) with load alignment/extension.
// Optional WB_RETIRE_CNT_EN adds a 64-bit retired-instruction counter on retire_cnt_o.
module wb_stage #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid_i,
    output logic        ex_ready_o,
    input  logic [4:0]  ex_rd_i,
    input  logic [63:0] ex_data_i,
    input  logic [63:0] ex_inst_addr_i,
    input  logic        lsu_valid_i,
    input  logic [4:0]  lsu_rd_i,
    input  logic [63:0] lsu_rdata_i,
    input  logic [2:0]  lsu_funct3_i,
    input  logic [2:0]  lsu_offset_i,
    input  logic [63:0] lsu_inst_addr_i,
    output logic        reg_wen_o,
    output logic [4:0]  reg_waddr_o,
    output logic [63:0] reg_wdata_o,
    output logic        retire_valid_o,
    output logic [63:0] inst_addr_o
`ifdef WB_RETIRE_CNT_EN
    ,output logic [63:0] retire_cnt_o
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [4:0]    fifo_rd   [DEPTH];
    logic [63:0]   fifo_data [DEPTH];
    logic [63:0]   fifo_pc   [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0]   cnt;
    logic          empty, push, pop, sel_valid;
    logic [4:0]    sel_rd;
    logic [63:0]   sel_data, sel_pc, sh, ld;

    assign empty      = cnt == '0;
    assign ex_ready_o = cnt != FULL;
    // The ALU only needs the FIFO when it loses to a load or must queue behind older entries.
    assign push = ex_valid_i && ex_ready_o && (lsu_valid_i || !empty);
    assign pop  = !lsu_valid_i && !empty;

    assign sh = lsu_rdata_i >> {lsu_offset_i, 3'b000};
    assign ld = lsu_funct3_i[1:0] == 2'd0 ? {{56{~lsu_funct3_i[2] & sh[7]}}, sh[7:0]} :
                lsu_funct3_i[1:0] == 2'd1 ? {{48{~lsu_funct3_i[2] & sh[15]}}, sh[15:0]} :
                lsu_funct3_i[1:0] == 2'd2 ? {{32{~lsu_funct3_i[2] & sh[31]}}, sh[31:0]} : sh;

    assign sel_valid = lsu_valid_i || !empty || ex_valid_i;
    assign sel_rd    = lsu_valid_i ? lsu_rd_i        : !empty ? fifo_rd[rp]   : ex_rd_i;
    assign sel_data  = lsu_valid_i ? ld              : !empty ? fifo_data[rp] : ex_data_i;
    assign sel_pc    = lsu_valid_i ? lsu_inst_addr_i : !empty ? fifo_pc[rp]   : ex_inst_addr_i;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd[wp]   <= ex_rd_i;
            fifo_data[wp] <= ex_data_i;
            fifo_pc[wp]   <= ex_inst_addr_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wp             <= '0;
            rp             <= '0;
            cnt            <= '0;
            reg_wen_o      <= 1'b0;
            reg_waddr_o    <= '0;
            reg_wdata_o    <= '0;
            retire_valid_o <= 1'b0;
            inst_addr_o    <= '0;
        end else begin
            if (push) wp <= wp + AW'(1);
            if (pop) rp <= rp + AW'(1);
            cnt            <= cnt + (AW+1)'(push) - (AW+1)'(pop);
            retire_valid_o <= sel_valid;
            reg_wen_o      <= sel_valid && sel_rd != 5'd0;
            if (sel_valid) begin
                reg_waddr_o <= sel_rd;
                reg_wdata_o <= sel_data;
                inst_addr_o <= sel_pc;
            end
        end
    end

`ifdef WB_RETIRE_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst) retire_cnt_o <= '0;
        else if (sel_valid) retire_cnt_o <= retire_cnt_o + 64'd1;
    end
`endif
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed vectors for wb_stage checked every cycle against a queue-based model,
// plus literal expectations at key points.
module tb_wb_stage;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid_i, ex_ready_o, lsu_valid_i;
    logic [4:0]  ex_rd_i, lsu_rd_i;
    logic [63:0] ex_data_i, ex_inst_addr_i, lsu_rdata_i, lsu_inst_addr_i;
    logic [2:0]  lsu_funct3_i, lsu_offset_i;
    logic        reg_wen_o, retire_valid_o;
    logic [4:0]  reg_waddr_o;
    logic [63:0] reg_wdata_o, inst_addr_o;
`ifdef WB_RETIRE_CNT_EN
    logic [63:0] retire_cnt_o;
`endif

    wb_stage #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o), .ex_rd_i(ex_rd_i),
        .ex_data_i(ex_data_i), .ex_inst_addr_i(ex_inst_addr_i),
        .lsu_valid_i(lsu_valid_i), .lsu_rd_i(lsu_rd_i), .lsu_rdata_i(lsu_rdata_i),
        .lsu_funct3_i(lsu_funct3_i), .lsu_offset_i(lsu_offset_i), .lsu_inst_addr_i(lsu_inst_addr_i),
        .reg_wen_o(reg_wen_o), .reg_waddr_o(reg_waddr_o), .reg_wdata_o(reg_wdata_o),
        .retire_valid_o(retire_valid_o), .inst_addr_o(inst_addr_o)
`ifdef WB_RETIRE_CNT_EN
        , .retire_cnt_o(retire_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [63:0] data;
        logic [63:0] pc;
    } ent_t;

    ent_t        q[$];
    logic        exp_valid, exp_wen;
    logic [4:0]  exp_waddr;
    logic [63:0] exp_wdata, exp_pc, exp_cnt;
    bit          started = 0;
    int          vectors = 0;
    int          miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Load extraction from arithmetic masks rather than bit slicing.
    function automatic logic [63:0] ext(input logic [63:0] d, input logic [2:0] f, input logic [2:0] off);
        logic [63:0] sh, mask, v;
        int bits;
        sh = d >> (int'(off) * 8);
        bits = (f[1:0] == 2'd0) ? 8 : (f[1:0] == 2'd1) ? 16 : (f[1:0] == 2'd2) ? 32 : 64;
        if (bits == 64) return sh;
        mask = (64'd1 << bits) - 64'd1;
        v = sh & mask;
        if (!f[2] && v[bits-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic void retire(input ent_t e);
        exp_valid = 1'b1;
        exp_wen   = e.rd != 5'd0;
        exp_waddr = e.rd;
        exp_wdata = e.data;
        exp_pc    = e.pc;
        exp_cnt   = exp_cnt + 64'd1;
    endfunction

    always @(posedge clk) begin
        ent_t ex, ld;
        bit acc;
        started = 1;
        ex = '{ex_rd_i, ex_data_i, ex_inst_addr_i};
        ld = '{lsu_rd_i, ext(lsu_rdata_i, lsu_funct3_i, lsu_offset_i), lsu_inst_addr_i};
        acc = ex_valid_i && q.size() < DEPTH;
        if (!rst) begin
            q.delete();
            exp_valid = 0; exp_wen = 0; exp_waddr = '0; exp_wdata = '0; exp_pc = '0; exp_cnt = '0;
        end else if (lsu_valid_i) begin
            retire(ld);
            if (acc) q.push_back(ex);
        end else if (q.size() > 0) begin
            retire(q.pop_front());
            if (acc) q.push_back(ex);
        end else if (ex_valid_i) begin
            retire(ex);
        end else begin
            exp_valid = 0;
            exp_wen   = 0;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("retire_valid", 64'(retire_valid_o), 64'(exp_valid));
            chk("reg_wen", 64'(reg_wen_o), 64'(exp_wen));
            chk("ex_ready", 64'(ex_ready_o), 64'(q.size() < DEPTH));
            chk("inst_addr", inst_addr_o, exp_pc);
            if (exp_wen) begin
                chk("reg_waddr", 64'(reg_waddr_o), 64'(exp_waddr));
                chk("reg_wdata", reg_wdata_o, exp_wdata);
            end
`ifdef WB_RETIRE_CNT_EN
            chk("retire_cnt", retire_cnt_o, exp_cnt);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ex_valid_i = 0;
        lsu_valid_i = 0;
    endtask

    task automatic set_ex(input logic [4:0] rd, input logic [63:0] d, input logic [63:0] pc);
        ex_valid_i = 1; ex_rd_i = rd; ex_data_i = d; ex_inst_addr_i = pc;
    endtask

    task automatic set_ld(input logic [4:0] rd, input logic [63:0] d, input logic [2:0] f,
                          input logic [2:0] off, input logic [63:0] pc);
        lsu_valid_i = 1; lsu_rd_i = rd; lsu_rdata_i = d; lsu_funct3_i = f;
        lsu_offset_i = off; lsu_inst_addr_i = pc;
    endtask

    logic [63:0] lv_data [6] = '{64'h80FF_0000_0000_0000, 64'h80FF_0000_0000_0000,
                                 64'h80FF_0000_0000_0000, 64'h8000_0001_0000_0000,
                                 64'h8000_0001_0000_0000, 64'h80FF_0000_0000_0000};
    logic [2:0]  lv_f3   [6] = '{3'd1, 3'd5, 3'd0, 3'd2, 3'd6, 3'd4};
    logic [2:0]  lv_off  [6] = '{3'd6, 3'd6, 3'd7, 3'd4, 3'd4, 3'd7};
    logic [63:0] lv_exp  [6] = '{64'hFFFF_FFFF_FFFF_80FF, 64'h0000_0000_0000_80FF,
                                 64'hFFFF_FFFF_FFFF_FF80, 64'hFFFF_FFFF_8000_0001,
                                 64'h0000_0000_8000_0001, 64'h0000_0000_0000_0080};

    initial begin
        int k;
        bit r;
        rst = 0;
        idle();
        set_ex(5'd7, 64'h77, 64'h100);
        set_ld(5'd0, 64'h0, 3'd0, 3'd0, 64'h0);
        lsu_valid_i = 0;
        tick(); tick();
        chk("rst_retire", 64'(retire_valid_o), 64'd0);
        chk("rst_wen", 64'(reg_wen_o), 64'd0);
        chk("rst_ready", 64'(ex_ready_o), 64'd1);
        rst = 1;
        tick();
        chk("rel_bypass_addr", 64'(reg_waddr_o), 64'd7);
        chk("rel_bypass_data", reg_wdata_o, 64'h77);

        set_ex(5'd5, 64'h1234, 64'h200);
        tick();
        chk("bypass_wen", 64'(reg_wen_o), 64'd1);
        chk("bypass_addr", 64'(reg_waddr_o), 64'd5);
        chk("bypass_data", reg_wdata_o, 64'h1234);
        chk("bypass_pc", inst_addr_o, 64'h200);
        idle();
        tick();
        chk("idle_retire", 64'(retire_valid_o), 64'd0);
        chk("idle_pc_hold", inst_addr_o, 64'h200);

        set_ex(5'd3, 64'hA, 64'h300);
        set_ld(5'd4, 64'h1122_3344_5566_7788, 3'd3, 3'd0, 64'h304);
        tick();
        chk("coll_load_addr", 64'(reg_waddr_o), 64'd4);
        chk("coll_load_data", reg_wdata_o, 64'h1122_3344_5566_7788);
        idle();
        tick();
        chk("coll_alu_addr", 64'(reg_waddr_o), 64'd3);
        chk("coll_alu_data", reg_wdata_o, 64'hA);
        tick();

        for (int i = 0; i < 6; i++) begin
            set_ld(5'd6, lv_data[i], lv_f3[i], lv_off[i], 64'h400 + 64'(i));
            tick();
            chk($sformatf("load_ext%0d", i), reg_wdata_o, lv_exp[i]);
        end
        idle();
        tick();

        k = 0;
        for (int c = 0; c < 6; c++) begin
            set_ex(5'(11 + k), 64'h500 + 64'(k), 64'h5000 + 64'(4 * k));
            set_ld(5'd10, 64'(c), 3'd3, 3'd0, 64'h6000 + 64'(c));
            r = ex_ready_o;
            tick();
            if (r) k++;
        end
        chk("full_accepts", 64'(k), 64'd4);
        chk("full_ready", 64'(ex_ready_o), 64'd0);
        lsu_valid_i = 0;
        for (int j = 0; j < 5; j++) begin
            r = ex_ready_o && ex_valid_i;
            tick();
            if (r) ex_valid_i = 0;
            chk($sformatf("drain_addr%0d", j), 64'(reg_waddr_o), 64'(11 + j));
        end
        idle();
        tick();

        set_ex(5'd0, 64'h99, 64'h600);
        tick();
        chk("rd0_retire", 64'(retire_valid_o), 64'd1);
        chk("rd0_wen", 64'(reg_wen_o), 64'd0);
        chk("rd0_pc", inst_addr_o, 64'h600);
        idle();

        for (int c = 0; c < 3; c++) begin
            set_ex(5'(20 + c), 64'h700 + 64'(c), 64'h7000 + 64'(c));
            set_ld(5'd9, 64'h55, 3'd3, 3'd0, 64'h7100 + 64'(c));
            tick();
        end
        idle();
        rst = 0;
        tick();
        chk("midrst_wen", 64'(reg_wen_o), 64'd0);
        chk("midrst_ready", 64'(ex_ready_o), 64'd1);
        rst = 1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk($sformatf("post_rst_retire%0d", c), 64'(retire_valid_o), 64'd0);
        end
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
